// File: rtl/cog_ctr_multi_if.sv
// Bus bundle for the multi-channel cog counter: strobes, pins and results.
// Parameters must match the attached cog_ctr_multi instance.
interface cog_ctr_multi_if #(
    parameter int NCH   = 2,
    parameter int PHS_W = 32,
    parameter int CH_W  = 1
);
    logic                       ena;
    logic [CH_W-1:0]            sel;
    logic                       setctr;
    logic                       setfrq;
    logic                       setphs;
    logic [NCH-1:0]             clr_wrap;
    logic [31:0]                data;
    logic [31:0]                pin_in;
    logic [NCH*(PHS_W+1)-1:0]   phs;
    logic [NCH-1:0]             wrap;
    logic [NCH*PHS_W-1:0]       cap;
    logic [31:0]                pin_out;

    modport master (
        output ena, sel, setctr, setfrq, setphs, clr_wrap, data, pin_in,
        input  phs, wrap, cap, pin_out
    );

    modport slave (
        input  ena, sel, setctr, setfrq, setphs, clr_wrap, data, pin_in,
        output phs, wrap, cap, pin_out
    );
endinterface

// File: rtl/cog_ctr_multi.sv
// NCH-channel cog counter: NCO/duty, pin accumulate and logic modes.
// Optional capture register per channel when CTR_CAPTURE_EN is defined.
module cog_ctr_multi #(
    parameter int NCH   = 2,
    parameter int PHS_W = 32,
    parameter int CH_W  = 1
) (
    input logic              clk_cog,
    input logic              res,
    cog_ctr_multi_if.slave   bus
);
    logic [31:0] chan_out [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [31:0]      ctr;
        logic [PHS_W-1:0] frq;
        logic [PHS_W:0]   acc;
        logic [PHS_W:0]   sum;
        logic             a0, a1, b0;
        logic             wrap_r;
        logic             trig, outa, outb, msb;
        logic [4:0]       mode, apin, bpin;
        logic             hit;
        logic             unused_bits;

        assign mode = ctr[30:26];
        assign bpin = ctr[13:9];
        assign apin = ctr[4:0];
        assign hit  = bus.sel == CH_W'(k);
        assign sum  = {1'b0, acc[PHS_W-1:0]} + {1'b0, frq};
        assign unused_bits = ^{ctr[31], ctr[25:14], ctr[8:5]};

        always_comb begin
            trig = 1'b0;
            outa = 1'b0;
            outb = 1'b0;
            msb  = mode[1] ? acc[PHS_W] : acc[PHS_W-1];
            unique case (1'b1)
                mode[4]: trig = mode[{b0, a0}];
                mode[4:3] == 2'b01: begin
                    unique case (mode[2:1])
                        2'b00: trig = a0;
                        2'b10: trig = !a0;
                        2'b01: trig = a0 & !a1;
                        2'b11: trig = !a0 & a1;
                    endcase
                    outb = mode[0] & !a0;
                end
                mode[4:2] == 3'b001: begin
                    trig = 1'b1;
                    outa = msb;
                    outb = mode[0] & !msb;
                end
                default: ;
            endcase
        end

        assign chan_out[k] = (32'(outb) << bpin) | (32'(outa) << apin);

        always_ff @(posedge clk_cog or posedge res) begin
            if (res) begin
                ctr <= '0;
                frq <= '0;
            end else begin
                if (!bus.ena)
                    ctr <= '0;
                else if (bus.setctr && hit)
                    ctr <= bus.data;
                if (bus.setfrq && hit)
                    frq <= bus.data[PHS_W-1:0];
            end
        end

        always_ff @(posedge clk_cog or posedge res) begin
            if (res) begin
                acc    <= '0;
                wrap_r <= 1'b0;
            end else if (bus.setphs && hit) begin
                acc    <= {1'b0, bus.data[PHS_W-1:0]};
                wrap_r <= 1'b0;
            end else begin
                if (trig)
                    acc <= sum;
                // a fresh carry beats a concurrent clear
                if (trig && sum[PHS_W])
                    wrap_r <= 1'b1;
                else if (bus.clr_wrap[k])
                    wrap_r <= 1'b0;
            end
        end

        always_ff @(posedge clk_cog or posedge res) begin
            if (res) begin
                a0 <= 1'b0;
                a1 <= 1'b0;
                b0 <= 1'b0;
            end else if (mode[4:3] != 2'b00) begin
                a0 <= bus.pin_in[apin];
                a1 <= a0;
                b0 <= bus.pin_in[bpin];
            end
        end

        assign bus.phs[k*(PHS_W+1) +: PHS_W+1] = acc;
        assign bus.wrap[k] = wrap_r;

`ifdef CTR_CAPTURE_EN
        logic             b0_prev;
        logic [PHS_W-1:0] cap_r;

        always_ff @(posedge clk_cog or posedge res) begin
            if (res) begin
                b0_prev <= 1'b0;
                cap_r   <= '0;
            end else begin
                if (mode[4:3] != 2'b00)
                    b0_prev <= b0;
                // latches the pre-update value, even under setphs
                if (mode[4:1] == 4'b0101 && b0 && !b0_prev)
                    cap_r <= acc[PHS_W-1:0];
            end
        end

        assign bus.cap[k*PHS_W +: PHS_W] = cap_r;
`else
        assign bus.cap[k*PHS_W +: PHS_W] = '0;
`endif
    end

    always_comb begin
        bus.pin_out = '0;
        for (int k = 0; k < NCH; k++)
            bus.pin_out = bus.pin_out | chan_out[k];
    end
endmodule
